bus_cmd_parser: RTL
===================

Name: bus_cmd_parser

Overview:
- Sits directly upstream of the memory core's register-bus input, between the UART byte receiver and the first core on the bus chain.
- Parses ASCII command lines arriving one byte at a time and issues one bus transaction per complete command:
  - "Raaaa" + terminator: read.
  - "Waaaadddd" + terminator: write.
- Drives the same addr/wdata/rdata/rw/valid bus the cores consume. Malformed input is discarded and flagged.

Parameters:
- ADDR_WIDTH, 16, bus address width. Must be a multiple of 4; address field is ADDR_WIDTH/4 hex digits.
- DATA_WIDTH, 16, bus data width. Must be a multiple of 4; data field is DATA_WIDTH/4 hex digits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_i  input  8  received byte from the UART receiver.
- valid_i  input  1  data_i valid this cycle. One-cycle strobe; may be asserted on consecutive cycles.
- addr_o  output  ADDR_WIDTH  bus address.
- wdata_o  output  DATA_WIDTH  bus write data. Write commands only; otherwise holds its last value.
- rdata_o  output  DATA_WIDTH  bus read data. Driven constant 0 (head of chain).
- rw_o  output  1  1 = write, 0 = read.
- valid_o  output  1  one-cycle transaction strobe.
- error_o  output  1  one-cycle strobe on a malformed command.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, digit counter=0, shift registers=0.
  - addr_o=0, wdata_o=0, rdata_o=0, rw_o=0, valid_o=0, error_o=0.
- Byte handling: only cycles with valid_i=1 are acted on; all other cycles leave state unchanged.
- Hex digits: 0x30-0x39, 0x41-0x46, 0x61-0x66 (case-insensitive). Shifted in MSB-first: reg <= {reg[W-5:0], nibble}.
- Terminator: CR (0x0D) or LF (0x0A).
- IDLE:
  - 'R'/'r' -> clear addr shift register and counter, latch is_write=0, go to ADDR.
  - 'W'/'w' -> same with is_write=1, go to ADDR.
  - CR/LF -> ignored, stay IDLE. This lets "\r\n" pairs pass silently.
  - Any other byte -> error_o pulse, stay IDLE.
- ADDR:
  - Hex digit -> shift in, increment counter.
  - On the ADDR_WIDTH/4-th digit: go to DATA if is_write (clear counter and data shift register), else go to END.
  - Non-hex byte, including an early terminator -> error_o pulse, go to IDLE.
- DATA: same as ADDR for DATA_WIDTH/4 digits, then go to END. Non-hex -> error_o, go to IDLE.
- END:
  - Terminator -> go to IDLE. On the next cycle (registered; latency 1 after the terminator's valid_i cycle):
    - valid_o=1 for exactly one cycle.
    - addr_o = address shift register, rw_o = is_write, wdata_o = data shift register if write.
  - Any other byte -> error_o pulse, go to IDLE, no transaction.
- Output hold: addr_o, wdata_o and rw_o hold their values until the next accepted transaction. Downstream cores sample them only when valid_o=1.
- Error timing: error_o is registered and asserts the cycle after the offending byte. error_o and valid_o are never high together.
- No backpressure: the next command may begin the cycle after the terminator. A byte arriving in the same cycle valid_o is high is processed normally from IDLE.
- Reset mid-command: partial command discarded, no valid_o or error_o is generated, parser restarts in IDLE.
- Back-to-back: no bytes are dropped when valid_i is high on consecutive cycles. Throughput is one byte per cycle.

Test Plan:
- Read: bytes "R0005\r" -> one valid_o pulse the cycle after '\r', with addr_o=0x0005, rw_o=0, and no error_o.
- Write (mixed case, LF): bytes "w00a3BEEF\n" on consecutive cycles -> valid_o once, with addr_o=0x00A3, wdata_o=0xBEEF, rw_o=1. Outputs then hold for 20 idle cycles with valid_o=0.
- CRLF then read: "W0001FFFF\r\nR0001\r\n" -> exactly two valid_o pulses:
  - first: addr 0x0001, rw=1, wdata=0xFFFF;
  - second: addr 0x0001, rw=0, wdata_o still 0xFFFF;
  - both LFs produce no error.
- Malformed input:
  - "R00G1\r": error_o pulses after 'G'; the trailing '1' and '\r' are handled in IDLE ('1' -> second error_o, '\r' ignored); no valid_o.
  - "W12\r": a single error_o pulse.
  - "X": error_o.
- Reset mid-command: send "W12" then assert rst asynchronously between clock edges -> all outputs 0 immediately. After release, "R1234\r" yields addr_o=0x1234, rw_o=0, and no spurious strobe.
- End-to-end with the memory core: drive "W00026789\r", then "R0002\r" through this block into the memory core. The core's valid_o returns rdata=0x6789 for the read.

Source files
------------

// File: rtl/bus_cmd_parser.sv
// ASCII command-line parser: turns "Raaaa<CR|LF>" / "Waaaadddd<CR|LF>" byte streams
// into single-cycle register-bus transactions, flagging malformed lines on error_o.
module bus_cmd_parser #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic                  error_o
);

  localparam int ADDR_DIGITS = ADDR_WIDTH / 4;
  localparam int DATA_DIGITS = DATA_WIDTH / 4;
  localparam int MAX_DIGITS  = (ADDR_DIGITS > DATA_DIGITS) ? ADDR_DIGITS : DATA_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_DIGITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  is_write;

  logic       is_hex;
  logic [3:0] nibble;
  logic       is_term;
  logic       is_rd_cmd;
  logic       is_wr_cmd;

  logic start;
  logic shift_addr;
  logic shift_data;
  logic issue;
  logic flag_err;

  // Returns {valid, nibble}; letters map via their low nibble plus 9 ('A'/'a' -> 10).
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39)
      hex_decode = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      hex_decode = {1'b1, b[3:0] + 4'd9};
    else
      hex_decode = 5'b0;
  endfunction

  assign {is_hex, nibble} = hex_decode(data_i);
  assign is_term   = (data_i == 8'h0D) || (data_i == 8'h0A);
  assign is_rd_cmd = (data_i == 8'h52) || (data_i == 8'h72);
  assign is_wr_cmd = (data_i == 8'h57) || (data_i == 8'h77);

  // Read commands have no bus-side data source upstream of the chain.
  assign rdata_o = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (valid_i) begin
      case (state)
        S_IDLE: if (is_rd_cmd || is_wr_cmd) state_next = S_ADDR;
        S_ADDR: begin
          if (!is_hex)                state_next = S_IDLE;
          else if (cnt == ADDR_LAST)  state_next = is_write ? S_DATA : S_END;
        end
        S_DATA: begin
          if (!is_hex)                state_next = S_IDLE;
          else if (cnt == DATA_LAST)  state_next = S_END;
        end
        default:                      state_next = S_IDLE;
      endcase
    end
  end

  // Bare CR/LF in IDLE is silently dropped so "\r\n" line endings never raise an error.
  always_comb begin
    start      = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    issue      = 1'b0;
    flag_err   = 1'b0;
    if (valid_i) begin
      case (state)
        S_IDLE: begin
          if (is_rd_cmd || is_wr_cmd) start    = 1'b1;
          else if (!is_term)          flag_err = 1'b1;
        end
        S_ADDR: begin
          if (is_hex) shift_addr = 1'b1;
          else        flag_err   = 1'b1;
        end
        S_DATA: begin
          if (is_hex) shift_data = 1'b1;
          else        flag_err   = 1'b1;
        end
        default: begin
          if (is_term) issue    = 1'b1;
          else         flag_err = 1'b1;
        end
      endcase
    end
  end

  // Byte stage -> registered bus outputs, one cycle after the deciding byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      is_write <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
      rw_o     <= 1'b0;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      valid_o <= issue;
      error_o <= flag_err;
      if (start) begin
        addr_sr  <= '0;
        cnt      <= '0;
        is_write <= is_wr_cmd;
      end
      if (shift_addr) begin
        addr_sr <= (addr_sr << 4) | ADDR_WIDTH'(nibble);
        if (cnt == ADDR_LAST) begin
          cnt     <= '0;
          data_sr <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (shift_data) begin
        data_sr <= (data_sr << 4) | DATA_WIDTH'(nibble);
        cnt     <= cnt + 1'b1;
      end
      if (issue) begin
        addr_o <= addr_sr;
        rw_o   <= is_write;
        if (is_write) wdata_o <= data_sr;
      end
    end
  end

endmodule
